// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: multi-CDB wakeup, oldest-ready-first issue
// into a held output register, with dispatch backpressure and occupancy count.
module age_ordered_rs #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 3,
  parameter int OP_WIDTH    = 5,
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_CDB     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              dispatch_valid,
  output logic                              dispatch_ready,
  input  logic [DATA_WIDTH-1:0]             src1_val,
  input  logic [DATA_WIDTH-1:0]             src2_val,
  input  logic [DATA_WIDTH-1:0]             src3_val,
  input  logic [TAG_WIDTH-1:0]              src1_tag,
  input  logic [TAG_WIDTH-1:0]              src2_tag,
  input  logic [TAG_WIDTH-1:0]              src3_tag,
  input  logic                              src1_ready,
  input  logic                              src2_ready,
  input  logic                              src3_ready,
  input  logic [OP_WIDTH-1:0]               opcode,
  input  logic [4:0]                        dest_reg,
  input  logic [TAG_WIDTH-1:0]              my_rob_tag,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]      cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]     cdb_value,
  output logic                              fu_valid,
  input  logic                              fu_ready,
  output logic [DATA_WIDTH-1:0]             fu_op1,
  output logic [DATA_WIDTH-1:0]             fu_op2,
  output logic [DATA_WIDTH-1:0]             fu_op3,
  output logic [OP_WIDTH-1:0]               fu_opcode,
  output logic [TAG_WIDTH-1:0]              fu_dest_tag,
  output logic [4:0]                        fu_dest_reg,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]  rs_count
);
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int IW = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [OP_WIDTH-1:0]    opc_q  [NUM_ENTRIES], opc_d  [NUM_ENTRIES];
  logic [4:0]             dreg_q [NUM_ENTRIES], dreg_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   rtag_q [NUM_ENTRIES], rtag_d [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  val_q  [NUM_ENTRIES][3], val_d [NUM_ENTRIES][3];
  logic [TAG_WIDTH-1:0]   stag_q [NUM_ENTRIES][3], stag_d [NUM_ENTRIES][3];
  logic [2:0]             rdy_q  [NUM_ENTRIES], rdy_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES], older_d [NUM_ENTRIES];

  logic                   fu_valid_q, fu_valid_d;
  logic [DATA_WIDTH-1:0]  fu_op_q [3], fu_op_d [3];
  logic [OP_WIDTH-1:0]    fu_opc_q, fu_opc_d;
  logic [TAG_WIDTH-1:0]   fu_tag_q, fu_tag_d;
  logic [4:0]             fu_dreg_q, fu_dreg_d;
  logic [CW-1:0]          count_q, count_d;

  logic [DATA_WIDTH-1:0]  in_val [3];
  logic [TAG_WIDTH-1:0]   in_tag [3];
  logic [2:0]             in_rdy;
  logic [NUM_ENTRIES-1:0] elig, blocked;
  logic                   sel_valid, load, accept;
  logic [IW-1:0]          sel_idx, alloc_idx;

  assign in_val = '{src1_val, src2_val, src3_val};
  assign in_tag = '{src1_tag, src2_tag, src3_tag};
  assign in_rdy = {src3_ready, src2_ready, src1_ready};

  assign dispatch_ready = ~(&busy_q);
  assign accept         = dispatch_valid & dispatch_ready;

  // Oldest eligible entry: no other eligible entry is marked older than it.
  always_comb begin
    elig      = '0;
    blocked   = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      elig[i] = busy_q[i] & (&rdy_q[i]);
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      for (int unsigned j = 0; j < NUM_ENTRIES; j++)
        if (elig[j] && older_q[j][i]) blocked[i] = 1'b1;
      if (elig[i] && !blocked[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int unsigned i = NUM_ENTRIES; i > 0; i--)
      if (!busy_q[i-1]) alloc_idx = IW'(i - 1);
  end

  assign load = (!fu_valid_q || fu_ready) && sel_valid;

  always_comb begin
    busy_d = busy_q;  opc_d = opc_q;  dreg_d = dreg_q;  rtag_d = rtag_q;
    val_d  = val_q;   stag_d = stag_q; rdy_d = rdy_q;   older_d = older_q;
    fu_valid_d = fu_valid_q;  fu_op_d = fu_op_q;  fu_opc_d = fu_opc_q;
    fu_tag_d   = fu_tag_q;    fu_dreg_d = fu_dreg_q;
    count_d    = count_q + (accept ? CW'(1) : CW'(0)) - (load ? CW'(1) : CW'(0));

    // Ports scanned high-to-low so the lowest matching port is written last.
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      for (int unsigned s = 0; s < 3; s++)
        for (int unsigned p = NUM_CDB; p > 0; p--)
          if (busy_q[i] && !rdy_q[i][s] && cdb_valid[p-1] &&
              cdb_tag[(p-1)*TAG_WIDTH +: TAG_WIDTH] == stag_q[i][s]) begin
            val_d[i][s] = cdb_value[(p-1)*DATA_WIDTH +: DATA_WIDTH];
            rdy_d[i][s] = 1'b1;
          end

    if (load) begin
      busy_d[sel_idx] = 1'b0;
      fu_valid_d      = 1'b1;
      fu_op_d         = val_q[sel_idx];
      fu_opc_d        = opc_q[sel_idx];
      fu_tag_d        = rtag_q[sel_idx];
      fu_dreg_d       = dreg_q[sel_idx];
    end else if (fu_ready) begin
      fu_valid_d = 1'b0;
    end

    if (accept) begin
      busy_d[alloc_idx] = 1'b1;
      opc_d[alloc_idx]  = opcode;
      dreg_d[alloc_idx] = dest_reg;
      rtag_d[alloc_idx] = my_rob_tag;
      for (int unsigned s = 0; s < 3; s++) begin
        stag_d[alloc_idx][s] = in_tag[s];
        val_d[alloc_idx][s]  = in_val[s];
        rdy_d[alloc_idx][s]  = in_rdy[s];
        for (int unsigned p = NUM_CDB; p > 0; p--)
          if (!in_rdy[s] && cdb_valid[p-1] &&
              cdb_tag[(p-1)*TAG_WIDTH +: TAG_WIDTH] == in_tag[s]) begin
            val_d[alloc_idx][s] = cdb_value[(p-1)*DATA_WIDTH +: DATA_WIDTH];
            rdy_d[alloc_idx][s] = 1'b1;
          end
      end
      older_d[alloc_idx] = '0;
      for (int unsigned j = 0; j < NUM_ENTRIES; j++)
        if (IW'(j) != alloc_idx) older_d[j][alloc_idx] = busy_q[j];
    end

    if (flush) begin
      busy_d     = '0;
      fu_valid_d = 1'b0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      fu_valid_q <= 1'b0;
      fu_opc_q   <= '0;
      fu_tag_q   <= '0;
      fu_dreg_q  <= '0;
      count_q    <= '0;
      for (int unsigned s = 0; s < 3; s++) fu_op_q[s] <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        opc_q[i]   <= '0;
        dreg_q[i]  <= '0;
        rtag_q[i]  <= '0;
        rdy_q[i]   <= '0;
        older_q[i] <= '0;
        for (int unsigned s = 0; s < 3; s++) begin
          val_q[i][s]  <= '0;
          stag_q[i][s] <= '0;
        end
      end
    end else begin
      busy_q     <= busy_d;
      opc_q      <= opc_d;
      dreg_q     <= dreg_d;
      rtag_q     <= rtag_d;
      val_q      <= val_d;
      stag_q     <= stag_d;
      rdy_q      <= rdy_d;
      older_q    <= older_d;
      fu_valid_q <= fu_valid_d;
      fu_op_q    <= fu_op_d;
      fu_opc_q   <= fu_opc_d;
      fu_tag_q   <= fu_tag_d;
      fu_dreg_q  <= fu_dreg_d;
      count_q    <= count_d;
    end
  end

  assign fu_valid    = fu_valid_q;
  assign fu_op1      = fu_op_q[0];
  assign fu_op2      = fu_op_q[1];
  assign fu_op3      = fu_op_q[2];
  assign fu_opcode   = fu_opc_q;
  assign fu_dest_tag = fu_tag_q;
  assign fu_dest_reg = fu_dreg_q;
  assign rs_count    = count_q;
endmodule
